// File: rtl/psum_mem_arbiter.sv
// Single-port psum SRAM arbiter for the OFIFO, SFU and host paths.
// Round-robin grant with SFU RMW lock, OFIFO urgency and read-return routing.
module psum_mem_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 104
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              of_valid,
    output logic              of_ready,
    input  logic [ADDR_W-1:0] of_addr,
    input  logic [DATA_W-1:0] of_wdata,
    input  logic              of_urgent,
    input  logic              sfu_valid,
    output logic              sfu_ready,
    input  logic              sfu_we,
    input  logic [ADDR_W-1:0] sfu_addr,
    input  logic [DATA_W-1:0] sfu_wdata,
    input  logic              sfu_lock,
    output logic              sfu_rvalid,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              CEN,
    output logic              WEN,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] D,
    input  logic [DATA_W-1:0] Q,
    output logic [15:0]       stall_cnt
);

    typedef enum logic [1:0] {G_OF, G_SFU, G_HOST} grant_e;
    typedef enum logic [1:0] {T_NONE, T_SFU, T_HOST} tag_e;

    grant_e last_grant_q;
    tag_e   tag_q;
    logic   lock_q;
    logic   gnt_of, gnt_sfu, gnt_host;
    logic   stall;

    always_comb begin
        gnt_of   = 1'b0;
        gnt_sfu  = 1'b0;
        gnt_host = 1'b0;
        if (!reset) begin
            if (of_urgent && of_valid) begin
                gnt_of = 1'b1;
            end else if (lock_q) begin
                // the lock reserves the port even when SFU is idle
                gnt_sfu = sfu_valid;
            end else begin
                case (last_grant_q)
                    G_OF: begin
                        if (sfu_valid)       gnt_sfu  = 1'b1;
                        else if (host_valid) gnt_host = 1'b1;
                        else if (of_valid)   gnt_of   = 1'b1;
                    end
                    G_SFU: begin
                        if (host_valid)      gnt_host = 1'b1;
                        else if (of_valid)   gnt_of   = 1'b1;
                        else if (sfu_valid)  gnt_sfu  = 1'b1;
                    end
                    default: begin
                        if (of_valid)        gnt_of   = 1'b1;
                        else if (sfu_valid)  gnt_sfu  = 1'b1;
                        else if (host_valid) gnt_host = 1'b1;
                    end
                endcase
            end
        end
    end

    assign of_ready   = gnt_of;
    assign sfu_ready  = gnt_sfu;
    assign host_ready = gnt_host;

    always_comb begin
        CEN = ~(gnt_of | gnt_sfu | gnt_host);
        WEN = ~(gnt_of | (gnt_sfu & sfu_we));
        A   = '0;
        D   = '0;
        if (gnt_of) begin
            A = of_addr;
            D = of_wdata;
        end else if (gnt_sfu) begin
            A = sfu_addr;
            D = sfu_wdata;
        end else if (gnt_host) begin
            A = host_addr;
        end
    end

    assign stall = (of_valid & ~gnt_of) | (sfu_valid & ~gnt_sfu)
                 | (host_valid & ~gnt_host);

    // gating with reset lets a reset in the return cycle drop the rvalid
    assign sfu_rvalid  = (tag_q == T_SFU) && !reset;
    assign host_rvalid = (tag_q == T_HOST) && !reset;
    assign rdata       = Q;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= G_HOST;
            lock_q       <= 1'b0;
            tag_q        <= T_NONE;
            stall_cnt    <= '0;
        end else begin
            if (gnt_of)        last_grant_q <= G_OF;
            else if (gnt_sfu)  last_grant_q <= G_SFU;
            else if (gnt_host) last_grant_q <= G_HOST;

            if (gnt_sfu && sfu_lock) lock_q <= 1'b1;
            else if (!sfu_lock)      lock_q <= 1'b0;

            if (gnt_sfu && !sfu_we) tag_q <= T_SFU;
            else if (gnt_host)      tag_q <= T_HOST;
            else                    tag_q <= T_NONE;

            if (stall && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_psum_mem_arbiter.sv
// Directed self-checking bench for psum_mem_arbiter.
// Includes a behavioural single-port SRAM with registered read data.
module tb_psum_mem_arbiter;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 104;

    logic              clk;
    logic              reset;
    logic              of_valid, of_ready, of_urgent;
    logic [ADDR_W-1:0] of_addr;
    logic [DATA_W-1:0] of_wdata;
    logic              sfu_valid, sfu_ready, sfu_we, sfu_lock, sfu_rvalid;
    logic [ADDR_W-1:0] sfu_addr;
    logic [DATA_W-1:0] sfu_wdata;
    logic              host_valid, host_ready, host_rvalid;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] rdata;
    logic              CEN, WEN;
    logic [ADDR_W-1:0] A;
    logic [DATA_W-1:0] D, Q;
    logic [15:0]       stall_cnt;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    psum_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .of_valid(of_valid), .of_ready(of_ready), .of_addr(of_addr),
        .of_wdata(of_wdata), .of_urgent(of_urgent),
        .sfu_valid(sfu_valid), .sfu_ready(sfu_ready), .sfu_we(sfu_we),
        .sfu_addr(sfu_addr), .sfu_wdata(sfu_wdata), .sfu_lock(sfu_lock),
        .sfu_rvalid(sfu_rvalid),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_addr(host_addr), .host_rvalid(host_rvalid),
        .rdata(rdata), .CEN(CEN), .WEN(WEN), .A(A), .D(D), .Q(Q),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!CEN) begin
            if (!WEN) mem[A] <= D;
            else      Q <= mem[A];
        end
    end

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        of_valid = 0; of_urgent = 0; sfu_valid = 0; host_valid = 0;
    endtask

    initial begin
        reset = 1; of_urgent = 0; sfu_we = 0; sfu_lock = 0;
        of_addr = 0; of_wdata = 0; sfu_addr = 0; sfu_wdata = 0;
        host_addr = 0;
        of_valid = 1; sfu_valid = 1; host_valid = 1;
        #1;
        chk("rst_of_ready", of_ready, 0);
        chk("rst_sfu_ready", sfu_ready, 0);
        chk("rst_host_ready", host_ready, 0);
        chk("rst_cen", CEN, 1);
        chk("rst_wen", WEN, 1);
        cyc(); cyc();
        reset = 0; idle();
        #1;
        chk("idle_cen", CEN, 1);
        chk("idle_a", A, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_rvalid", {sfu_rvalid, host_rvalid}, 0);

        // OFIFO writes 0..3, then host reads them back
        for (int i = 0; i < 4; i++) begin
            of_valid = 1; of_addr = i; of_wdata = i + 1;
            #1;
            chk("wr_ready", of_ready, 1);
            chk("wr_cen", CEN, 0);
            chk("wr_wen", WEN, 0);
            chk("wr_addr", A, i);
            chk("wr_data", D, i + 1);
            cyc();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            host_valid = 1; host_addr = i;
            #1;
            chk("rd_ready", host_ready, 1);
            chk("rd_wen", WEN, 1);
            chk("rd_d", D, 0);
            cyc();
            chk("rd_rvalid", host_rvalid, 1);
            chk("rd_data", rdata, i + 1);
        end
        idle();
        cyc();
        chk("rd_rvalid_end", host_rvalid, 0);
        chk("solo_stall", stall_cnt, 0);

        // all three contend: OF, SFU, HOST x3
        of_valid = 1; of_addr = 5; of_wdata = 'h55;
        sfu_valid = 1; sfu_we = 0; sfu_addr = 0;
        host_valid = 1; host_addr = 1;
        for (int k = 0; k < 9; k++) begin
            #1;
            chk("rr_of", of_ready, (k % 3) == 0);
            chk("rr_sfu", sfu_ready, (k % 3) == 1);
            chk("rr_host", host_ready, (k % 3) == 2);
            cyc();
            chk("rr_sfu_rv", sfu_rvalid, (k % 3) == 1);
            chk("rr_host_rv", host_rvalid, (k % 3) == 2);
            if ((k % 3) == 1) chk("rr_sfu_data", rdata, 1);
            if ((k % 3) == 2) chk("rr_host_data", rdata, 2);
        end
        idle();
        chk("rr_stall", stall_cnt, 9);

        // SFU read-modify-write holds the port against host
        sfu_valid = 1; sfu_we = 0; sfu_addr = 5; sfu_lock = 1;
        host_valid = 1; host_addr = 5;
        #1;
        chk("lk_rd_sfu", sfu_ready, 1);
        chk("lk_rd_host", host_ready, 0);
        cyc();
        chk("lk_sfu_rv", sfu_rvalid, 1);
        chk("lk_rd_data", rdata, 'h55);
        sfu_we = 1; sfu_wdata = 'h77; sfu_lock = 0;
        #1;
        chk("lk_wr_sfu", sfu_ready, 1);
        chk("lk_wr_host", host_ready, 0);
        chk("lk_wr_wen", WEN, 0);
        cyc();
        chk("lk_wr_rv", sfu_rvalid, 0);
        sfu_valid = 0; sfu_we = 0;
        #1;
        chk("lk_host_gnt", host_ready, 1);
        cyc();
        chk("lk_host_rv", host_rvalid, 1);
        chk("lk_host_data", rdata, 'h77);
        chk("lk_stall", stall_cnt, 11);
        idle();

        // urgent OFIFO cuts through a held lock
        sfu_valid = 1; sfu_we = 0; sfu_addr = 6; sfu_lock = 1;
        #1;
        chk("ur_lock_gnt", sfu_ready, 1);
        cyc();
        of_valid = 1; of_urgent = 1; of_addr = 7; of_wdata = 'h99;
        host_valid = 1; host_addr = 0;
        #1;
        chk("ur_of", of_ready, 1);
        chk("ur_sfu", sfu_ready, 0);
        chk("ur_addr", A, 7);
        cyc();
        of_valid = 0; of_urgent = 0;
        #1;
        chk("ur_sfu_next", sfu_ready, 1);
        chk("ur_host_next", host_ready, 0);
        cyc();

        // lock still held with SFU idle: port stays reserved
        sfu_valid = 0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("lkidle_cen", CEN, 1);
            chk("lkidle_host", host_ready, 0);
            cyc();
        end
        sfu_lock = 0;
        cyc();
        chk("lkfree_host", host_ready, 1);
        chk("lkfree_cen", CEN, 0);
        cyc();
        chk("lkfree_rv", host_rvalid, 1);
        chk("lkfree_data", rdata, 1);

        // reset lands in the read-return cycle
        host_valid = 1; host_addr = 2;
        #1;
        chk("mr_host_gnt", host_ready, 1);
        cyc();
        idle();
        reset = 1;
        #1;
        chk("mr_rvalid", host_rvalid, 0);
        chk("mr_cen", CEN, 1);
        cyc();
        reset = 0;
        of_valid = 1; of_addr = 9; sfu_valid = 1; host_valid = 1;
        #1;
        chk("mr_rvalid_after", host_rvalid, 0);
        chk("mr_of_first", of_ready, 1);
        chk("mr_stall", stall_cnt, 0);
        cyc();
        idle();
        chk("mr_stall_cnt", stall_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
